// File: rtl/y_capture_fifo_if.sv
// Handshake bundle for the y capture FIFO: producer side (in_*) and consumer side (out_*).
// Define Y_CAPTURE_PARITY_EN to add the out_parity / parity_err signals.
interface y_capture_fifo_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [ADDR_W:0]  count;
`ifdef Y_CAPTURE_PARITY_EN
  logic             out_parity;
  logic             parity_err;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count, out_parity, parity_err
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count, out_parity, parity_err
  );
`else
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );
`endif
endinterface

// File: rtl/y_capture_fifo.sv
// First-word-fall-through capture FIFO for the 32-bit y result; a word written at edge N is visible after edge N.
// Optional per-entry parity with Y_CAPTURE_PARITY_EN; in_ready drops when full or in reset.
module y_capture_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input logic            clk,
  input logic            rst,
  y_capture_fifo_if.slave bus
);
  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);
`ifdef Y_CAPTURE_PARITY_EN
  localparam int ENTRY_W = WIDTH + 1;
`else
  localparam int ENTRY_W = WIDTH;
`endif

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W:0]    occ;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] head;
  logic               full;
  logic               empty;
  logic               wr_en;
  logic               rd_en;

  assign full  = (occ == FULL_CNT);
  assign empty = (occ == '0);

  // A full FIFO refuses writes even when the head is being read this cycle.
  assign bus.in_ready  = !rst && !full;
  assign bus.out_valid = !empty;
  assign bus.count     = occ;

  assign wr_en = bus.in_valid && bus.in_ready;
  assign rd_en = bus.out_valid && bus.out_ready;

`ifdef Y_CAPTURE_PARITY_EN
  assign wr_entry = {^bus.in_data, bus.in_data};
`else
  assign wr_entry = bus.in_data;
`endif

  assign head         = mem[rd_ptr];
  assign bus.out_data = empty ? '0 : head[WIDTH-1:0];

`ifdef Y_CAPTURE_PARITY_EN
  assign bus.out_parity = empty ? 1'b0 : head[WIDTH];
  assign bus.parity_err = bus.out_valid && (bus.out_parity != ^bus.out_data);
`endif

  // Storage is deliberately left out of reset; stale entries are unreachable once occ is 0.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (wr_en) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({wr_en, rd_en})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end
endmodule

// File: tb/tb_y_capture_fifo.sv
// Directed plus randomized checks of y_capture_fifo against a queue-based reference model.
module tb_y_capture_fifo;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  logic [31:0] q[$];

  y_capture_fifo_if #(.WIDTH(32), .DEPTH(4)) bus ();

  y_capture_fifo #(.WIDTH(32), .DEPTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: set inputs away from the edge, check outputs against the model, then clock.
  task automatic step(input logic iv, input logic [31:0] id, input logic ordy, input logic r, input string tag);
    logic wr;
    logic rd;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    rst           = r;
    #1;
    check({tag, ".in_ready"},  {31'b0, bus.in_ready},  {31'b0, (!r && q.size() != 4)});
    check({tag, ".out_valid"}, {31'b0, bus.out_valid}, {31'b0, (q.size() != 0)});
    check({tag, ".out_data"},  bus.out_data, (q.size() != 0) ? q[0] : 32'h0);
    check({tag, ".count"},     {29'b0, bus.count}, q.size());
`ifdef Y_CAPTURE_PARITY_EN
    check({tag, ".out_parity"}, {31'b0, bus.out_parity}, {31'b0, (q.size() != 0) ? ^q[0] : 1'b0});
    check({tag, ".parity_err"}, {31'b0, bus.parity_err}, 32'h0);
`endif
    if (r) begin
      q.delete();
    end else begin
      wr = iv && (q.size() != 4);
      rd = ordy && (q.size() != 0);
      if (rd) void'(q.pop_front());
      if (wr) q.push_back(id);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] fill [4];
    fill[0] = 32'h00000001;
    fill[1] = 32'h00001000;
    fill[2] = 32'h10000000;
    fill[3] = 32'h00000000;

    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst           = 1'b1;
    @(posedge clk);
    #1;

    // Reset held with in_valid high: nothing captured
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, "rst0");
    step(1'b1, 32'hDEADBEEF, 1'b0, 1'b1, "rst1");
    step(1'b0, 32'h0, 1'b0, 1'b0, "post_rst");

    // Single word, then one-cycle read
    step(1'b1, 32'h00001000, 1'b0, 1'b0, "single_wr");
    step(1'b0, 32'h0, 1'b1, 1'b0, "single_rd");
    step(1'b0, 32'h0, 1'b0, 1'b0, "single_empty");

    // Fill, reject a 5th word, drain in order
    for (int i = 0; i < 4; i++) step(1'b1, fill[i], 1'b0, 1'b0, "fill");
    step(1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, "full_hold");
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "drain");
    step(1'b0, 32'h0, 1'b1, 1'b0, "empty_rd");

    // Full with simultaneous read and write: read only, write lands next cycle
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + i, 1'b0, 1'b0, "fill2");
    step(1'b1, 32'hB0, 1'b1, 1'b0, "full_rdwr");
    step(1'b1, 32'hB0, 1'b0, 1'b0, "refill");
    for (int i = 0; i < 4; i++) step(1'b0, 32'h0, 1'b1, 1'b0, "drain2");

    // Streaming through wraps the pointers
    for (int i = 0; i < 10; i++) step(1'b1, i, 1'b1, 1'b0, "stream");
    step(1'b0, 32'h0, 1'b1, 1'b0, "stream_tail");
    step(1'b0, 32'h0, 1'b0, 1'b0, "stream_empty");

    // Mid-operation reset with three words pending
    for (int i = 0; i < 3; i++) step(1'b1, 32'hC0 + i, 1'b0, 1'b0, "pre_rst");
    step(1'b0, 32'h0, 1'b0, 1'b1, "mid_rst");
    step(1'b1, 32'h00000001, 1'b0, 1'b0, "after_rst_wr");
    step(1'b0, 32'h0, 1'b0, 1'b0, "after_rst_head");

`ifdef Y_CAPTURE_PARITY_EN
    // Corrupt the stored head word; stored parity no longer matches.
    dut.mem[dut.rd_ptr] = dut.mem[dut.rd_ptr] ^ 33'h1;
    #1;
    check("flip.parity_err", {31'b0, bus.parity_err}, 32'h1);
    check("flip.out_parity", {31'b0, bus.out_parity}, 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    q.delete();
`endif
    step(1'b0, 32'h0, 1'b1, 1'b1, "clear");

    // Randomized traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0),
           ($urandom_range(0, 60) == 0), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
